sum_cmp_sched: RTL and testbench
================================

Name: sum_cmp_sched

Overview:
- Shares one pipelined Shannon-style add-compare unit among NREQ requesters.
- The unit computes (a+b+cin) mod 2^W == c.
- Both carry-in cases are precomputed speculatively; the registered cin picks one.
- Round-robin arbitration, 2-stage pipeline with backpressure, and a saturating match counter for firmware statistics.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand width
- IDW, 2, requester-id width; must equal clog2(NREQ)
- CNTW, 16, match-counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_en  in  1  1 = grants allowed; 0 = no new grants, in-flight results still drain
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, at most one bit high
- req_a  in  NREQ*W  operand a, requester i at slice [i*W +: W]
- req_b  in  NREQ*W  operand b, same packing
- req_c  in  NREQ*W  compare value, same packing
- req_cin  in  NREQ  late carry-in bit
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_id  out  IDW  requester index of the result
- res_match  out  1  1 when (a+b+cin) mod 2^W == c
- res_sum  out  W  selected sum (a+b+cin) mod 2^W
- stat_clr  in  1  synchronous clear of match_cnt
- match_cnt  out  CNTW  saturating count of delivered results with match=1

Behaviour:
- Reset values:
  - req_ready=0, res_valid=0, res_id=0, res_match=0, res_sum=0, match_cnt=0.
  - RR pointer = NREQ-1, so requester 0 has top priority first.
  - S1 and S2 valid flags = 0.
  - Reset is async assert, sync deassert assumed upstream.
  - Reset mid-operation discards all in-flight work; nothing is reissued.
- Transfer rules:
  - Handshake transfer on valid&ready on both interfaces.
  - Once valid is high, a requester holds valid and operands stable until accepted.
- Arbitration:
  - Candidates = req_valid when cfg_en=1 and S1 can load.
  - S1 can load = !s1_v | s1_adv.
  - Grant the first candidate searching from ptr+1 upward with wrap.
  - req_ready = one-hot grant, combinational.
  - ptr <= granted index on accept only; otherwise ptr is unchanged.
- Stage S1 (accept edge T):
  - Register a, b, c, cin, id.
  - Compute combinationally from registers: sum0=a+b, sum1=a+b+1 (W bits, carry-out dropped), eq0=(sum0==c), eq1=(sum1==c).
- Stage S2 (edge T+1, when s1_adv):
  - Register match = cin ? eq1 : eq0, and sum = cin ? sum1 : sum0, plus id.
  - res_* are driven directly from S2 registers.
  - res_valid is first high in the cycle after edge T+1, i.e. latency 2 cycles accept-to-valid.
- Flow control:
  - s2_adv = !s2_v | res_ready.
  - s1_adv = s1_v & s2_adv.
  - S2 output holds stable while res_valid & !res_ready.
  - Full throughput is one result per cycle when res_ready stays 1.
  - When res_ready=0: at most 2 transactions are in flight, then req_ready goes all-0.
- Simultaneous accept and deliver in the same cycle is allowed at both stages; no bubble is inserted.
- match_cnt:
  - Increments on a res_valid & res_ready & res_match cycle.
  - Saturates at all-ones.
  - stat_clr has priority: if clear and increment coincide, the result is 0.
- cfg_en falling: accepts no further requests; results already in S1/S2 still complete normally.
- Arithmetic wraps mod 2^W.

Decomposition:
- Package sum_cmp_pkg holds:
  - W/NREQ/IDW defaults.
  - A struct for the S1 payload {a,b,c,cin,id}.
  - A localparam for the reset pointer value.
- One sub-module: rr_arbiter (NREQ-wide req/grant, pointer register, advance-on-accept input), reusable elsewhere.
- The add-compare speculative pair stays inline.

Test Plan:
- Reset check: assert rst_n=0 with all inputs driving -> all outputs 0; release, then req0 a=3,b=4,c=7,cin=0 accepted at T -> res_valid at T+2, res_id=0, res_match=1, res_sum=7, match_cnt=1.
- Carry-in select and wrap: req1 a=200,b=100,c=45,cin=1 -> res_sum=45, match=1; same with cin=0 -> res_sum=44, match=0.
- Round-robin: all 4 req_valid held with res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; results return in order with ids 0,1,2,3,0 starting 2 cycles after the first grant.
- Backpressure: res_ready=0 for 6 cycles with continuous requests -> exactly 2 accepts, then req_ready=0; res_* stable; on res_ready=1 results drain in order with no loss or duplication.
- cfg_en and counter:
  - cfg_en=0 with pending requests -> no grants; in-flight results still delivered.
  - Preload toward saturation (CNTW=4, 16 matching results) -> match_cnt stays 15.
  - stat_clr coinciding with a match -> 0.
- Async reset mid-flight: assert rst_n with S1 and S2 full -> res_valid drops immediately; after release no stale result appears and the first grant goes to requester 0.

Source files
------------

// File: rtl/sum_cmp_pkg.sv
// Shared types and defaults for the shared add-compare scheduler.
package sum_cmp_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int IDW_DEF  = 2;
  localparam int CNTW_DEF = 16;

  // Operands captured in stage S1. The layout is fixed at the package widths,
  // so W and IDW of the top must match W_DEF and IDW_DEF.
  typedef struct packed {
    logic [W_DEF-1:0]   a;
    logic [W_DEF-1:0]   b;
    logic [W_DEF-1:0]   c;
    logic               cin;
    logic [IDW_DEF-1:0] id;
  } s1_payload_t;

  // The pointer starts on the last requester so that requester 0 wins first.
  function automatic int rr_ptr_rst(input int n);
    return n - 1;
  endfunction

  localparam int RR_PTR_RST = rr_ptr_rst(NREQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves to the winner on accept.
module rr_arbiter #(
  parameter int             N       = 4,
  parameter int             IDW     = 2,
  parameter logic [IDW-1:0] PTR_RST = IDW'(N - 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           accept,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  logic [IDW-1:0] ptr;
  logic           found;

  // Search from ptr+1 upward with wrap; the first requester found wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise the
    // no-request path would hold old values and infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                      = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        grant_idx                  = IDW'((int'(ptr) + k) % N);
      end
    end
  end

  // Pointer remembers the last accepted requester; unchanged otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      ptr <= PTR_RST;
    end else if (accept) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/sum_cmp_sched.sv
// Shares one 2-stage speculative add-compare unit among NREQ requesters.
module sum_cmp_sched
  import sum_cmp_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = IDW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  input  logic [NREQ-1:0]   req_cin,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic              res_match,
  output logic [W-1:0]      res_sum,
  input  logic              stat_clr,
  output logic [CNTW-1:0]   match_cnt
);

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            accept;
  logic            s1_load;
  logic            s1_adv;
  logic            s2_adv;

  s1_payload_t     s1_d;
  s1_payload_t     s1_q;
  logic            s1_v;

  logic [W-1:0]    sum0;
  logic [W-1:0]    sum1;
  logic            eq0;
  logic            eq1;

  logic            s2_v;
  logic            s2_match;
  logic [W-1:0]    s2_sum;
  logic [IDW-1:0]  s2_id;

  // Flow control: S2 frees when empty or drained, S1 moves when S2 can take it.
  assign s2_adv  = !s2_v || res_ready;
  assign s1_adv  = s1_v && s2_adv;
  assign s1_load = !s1_v || s1_adv;

  // Requests compete only when enabled, out of reset, and S1 has room.
  assign cand      = (cfg_en && rst_n && s1_load) ? req_valid : '0;
  assign accept    = |grant;
  assign req_ready = grant;

  rr_arbiter #(
    .N       (NREQ),
    .IDW     (IDW),
    .PTR_RST (IDW'(rr_ptr_rst(NREQ)))
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (cand),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Select the granted requester's operands into the S1 payload.
  always_comb begin
    s1_d     = '0;
    s1_d.a   = req_a[int'(grant_idx)*W +: W];
    s1_d.b   = req_b[int'(grant_idx)*W +: W];
    s1_d.c   = req_c[int'(grant_idx)*W +: W];
    s1_d.cin = req_cin[grant_idx];
    s1_d.id  = grant_idx;
  end

  // Stage S1: capture operands on accept; empties when it advances unrefilled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      // NOTE: payload registers are reset too; it costs little here and keeps
      // res_* at a defined 0 rather than relying on valid gating alone.
      s1_q <= '0;
    end else if (s1_load) begin
      s1_v <= accept;
      if (accept) begin
        s1_q <= s1_d;
      end
    end
  end

  // Speculative pair: both carry-in outcomes are ready before cin selects.
  assign sum0 = s1_q.a + s1_q.b;
  assign sum1 = sum0 + W'(1);
  assign eq0  = (sum0 == s1_q.c);
  assign eq1  = (sum1 == s1_q.c);

  // Stage S2: pick the outcome for the registered cin; holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      s2_match <= 1'b0;
      s2_sum   <= '0;
      s2_id    <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_match <= s1_q.cin ? eq1 : eq0;
        s2_sum   <= s1_q.cin ? sum1 : sum0;
        s2_id    <= s1_q.id;
      end
    end
  end

  assign res_valid = s2_v;
  assign res_match = s2_match;
  assign res_sum   = s2_sum;
  assign res_id    = s2_id;

  // Saturating count of delivered matches; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (stat_clr) begin
      match_cnt <= '0;
    end else if (s2_v && res_ready && s2_match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_sum_cmp_sched.sv
// Directed bench for sum_cmp_sched: drives on the falling edge, checks 1ns later.
module tb_sum_cmp_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*W-1:0] req_c;
  logic [NREQ-1:0]   req_cin;
  logic              res_valid;
  logic              res_ready;
  logic [IDW-1:0]    res_id;
  logic              res_match;
  logic [W-1:0]      res_sum;
  logic              stat_clr;
  logic [CNTW-1:0]   match_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int accepts = 0;

  sum_cmp_sched #(
    .NREQ (NREQ),
    .W    (W),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_match (res_match),
    .res_sum   (res_sum),
    .stat_clr  (stat_clr),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic cin);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
    req_cin[i]      = cin;
  endtask

  // Requester i: a=10i, b=i, c=11i, cin=0 -> sum 11i, always a match.
  task automatic set_std();
    for (int i = 0; i < NREQ; i++) set_req(i, W'(10*i), W'(i), W'(11*i), 1'b0);
  endtask

  initial begin
    // Reset with inputs active: every output must read 0.
    rst_n = 1'b0; cfg_en = 1'b1; res_ready = 1'b1; stat_clr = 1'b0;
    req_valid = '1; req_a = '0; req_b = '0; req_c = '0; req_cin = '0;
    set_std();
    #2;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_id",    32'(res_id), 0);
    check("rst_res_match", 32'(res_match), 0);
    check("rst_res_sum",   32'(res_sum), 0);
    check("rst_match_cnt", 32'(match_cnt), 0);

    // First transaction: 3+4+0 == 7, latency 2.
    tick(); rst_n = 1'b1; req_valid = 4'b0001; set_req(0, 8'd3, 8'd4, 8'd7, 1'b0);
    #1 check("t1_ready", 32'(req_ready), 32'b0001);
    tick(); req_valid = '0;
    #1 check("t1_valid_early", 32'(res_valid), 0);
    tick();
    #1 check("t1_valid", 32'(res_valid), 1);
    check("t1_id",    32'(res_id), 0);
    check("t1_match", 32'(res_match), 1);
    check("t1_sum",   32'(res_sum), 7);
    tick();
    #1 check("t1_cnt", 32'(match_cnt), 1);
    check("t1_valid_gone", 32'(res_valid), 0);

    // Carry-in select with wrap: 200+100+1 = 301 -> 45; with cin=0 -> 44.
    tick(); req_valid = 4'b0010; set_req(1, 8'd200, 8'd100, 8'd45, 1'b1);
    #1 check("cin1_ready", 32'(req_ready), 32'b0010);
    tick(); set_req(1, 8'd200, 8'd100, 8'd45, 1'b0);
    #1 check("cin0_ready", 32'(req_ready), 32'b0010);
    tick(); req_valid = '0;
    #1 check("cin1_valid", 32'(res_valid), 1);
    check("cin1_id",    32'(res_id), 1);
    check("cin1_sum",   32'(res_sum), 45);
    check("cin1_match", 32'(res_match), 1);
    tick();
    #1 check("cin0_valid", 32'(res_valid), 1);
    check("cin0_sum",   32'(res_sum), 44);
    check("cin0_match", 32'(res_match), 0);
    tick();
    #1 check("cin_drain", 32'(res_valid), 0);
    check("cin_cnt", 32'(match_cnt), 2);

    // Reset again so the pointer starts from requester 0.
    tick(); rst_n = 1'b0; set_std();
    tick(); rst_n = 1'b1; req_valid = '1; res_ready = 1'b1;
    #1 check("rst2_cnt", 32'(match_cnt), 0);

    // Round robin at full throughput: grants 0,1,2,3,0; results follow 2 later.
    for (int k = 0; k < 5; k++) begin
      if (k > 0) #1;
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        check($sformatf("rr_res_id%0d", k),  32'(res_id), 32'((k - 2) % 4));
        check($sformatf("rr_res_sum%0d", k), 32'(res_sum), 32'(11 * ((k - 2) % 4)));
      end
      tick();
    end
    req_valid = '0;
    #1 check("rr_tail_valid3", 32'(res_valid), 1);
    check("rr_tail_id3", 32'(res_id), 3);
    check("rr_tail_sum3", 32'(res_sum), 33);
    tick();
    #1 check("rr_tail_id0", 32'(res_id), 0);
    check("rr_tail_valid0", 32'(res_valid), 1);
    tick();
    #1 check("rr_empty", 32'(res_valid), 0);
    check("rr_cnt", 32'(match_cnt), 5);

    // Backpressure: two accepts (req1, req2) then all ready bits drop.
    tick(); res_ready = 1'b0; req_valid = '1;
    for (int j = 0; j < 6; j++) begin
      #1;
      check($sformatf("bp_ready%0d", j), 32'(req_ready),
            (j == 0) ? 32'b0010 : (j == 1) ? 32'b0100 : 32'b0000);
      if (req_ready != '0) accepts++;
      if (j >= 2) begin
        check($sformatf("bp_hold_valid%0d", j), 32'(res_valid), 1);
        check($sformatf("bp_hold_id%0d", j),    32'(res_id), 1);
        check($sformatf("bp_hold_sum%0d", j),   32'(res_sum), 11);
      end
      tick();
    end
    check("bp_accepts", 32'(accepts), 2);
    res_ready = 1'b1; req_valid = '0;
    #1 check("bp_drain_id1", 32'(res_id), 1);
    check("bp_drain_valid1", 32'(res_valid), 1);
    tick();
    #1 check("bp_drain_id2", 32'(res_id), 2);
    check("bp_drain_sum2", 32'(res_sum), 22);
    check("bp_drain_valid2", 32'(res_valid), 1);
    tick();
    #1 check("bp_drain_empty", 32'(res_valid), 0);
    check("bp_cnt", 32'(match_cnt), 7);

    // cfg_en low: in-flight req3 still completes, nothing new is granted.
    tick(); req_valid = 4'b1000;
    #1 check("cfg_grant3", 32'(req_ready), 32'b1000);
    tick(); cfg_en = 1'b0; req_valid = '1;
    #1 check("cfg_off_ready_a", 32'(req_ready), 0);
    tick();
    #1 check("cfg_off_ready_b", 32'(req_ready), 0);
    check("cfg_inflight_valid", 32'(res_valid), 1);
    check("cfg_inflight_id", 32'(res_id), 3);
    tick();
    #1 check("cfg_off_empty", 32'(res_valid), 0);
    check("cfg_off_ready_c", 32'(req_ready), 0);
    check("cfg_cnt", 32'(match_cnt), 8);

    // Saturation: 16 more matches on a 4-bit counter must stop at 15.
    cfg_en = 1'b1;
    for (int j = 0; j < 16; j++) tick();
    req_valid = '0;
    tick(); tick(); tick();
    #1 check("sat_cnt", 32'(match_cnt), 15);

    // stat_clr coinciding with a delivered match yields 0.
    tick(); req_valid = 4'b0001;
    #1 check("clr_grant", 32'(req_ready), 32'b0001);
    tick(); req_valid = '0;
    tick();
    #1 check("clr_res_match", 32'(res_match), 1);
    check("clr_res_valid", 32'(res_valid), 1);
    stat_clr = 1'b1;
    tick(); stat_clr = 1'b0;
    #1 check("clr_cnt", 32'(match_cnt), 0);

    // Async reset with S1 and S2 full: outputs drop at once, no stale result.
    tick(); res_ready = 1'b0; req_valid = '1;
    tick(); tick();
    #1 check("mid_s2_full", 32'(res_valid), 1);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_valid", 32'(res_valid), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    tick(); rst_n = 1'b1; res_ready = 1'b1;
    #1 check("mid_first_grant", 32'(req_ready), 32'b0001);
    tick(); req_valid = '0;
    #1 check("mid_no_stale", 32'(res_valid), 0);
    tick();
    #1 check("mid_new_valid", 32'(res_valid), 1);
    check("mid_new_id", 32'(res_id), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
